// File: rtl/seq_mul.sv
// seq_mul: sequential unsigned shift-add multiplier, one partial product per clock.
// Ports: clk, rst_n (sync, active-low), start/a/b in; op product, done strobe, busy out.
module seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] op,
  output logic               done,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   sum;
  logic            last;
  logic            accept;

  // DONE accepts a new start just like IDLE so results can stream back-to-back
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    sum = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = CALC;
      CALC: if (last) nxt = DONE;
      DONE: nxt = start ? CALC : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // busy and done decode the state register only, so they stay registered
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      op     <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last) op <= sum;
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: directed and randomized checks of seq_mul against a*b.
// Drives and samples on the falling edge of clk.
module tb_seq_mul;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] op;
  logic           done;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] last_op;

  seq_mul #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .op   (op),
    .done (done),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = '0;
    b = '0;
  endtask

  // Walks the CALC cycles, optionally pokes start mid-run, then checks
  // the done cycle. Returns on the falling edge where done should be high.
  task automatic wait_done(input logic [2*W-1:0] exp, input bit poke);
    for (int i = 0; i < W; i++) begin
      chk("calc_busy", 16'(busy), 16'd1);
      chk("calc_done", 16'(done), 16'd0);
      chk("calc_hold", 16'(op), 16'(last_op));
      if (poke && i == 1) begin
        start = 1'b1;
        a = 4'd2;
        b = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_hi", 16'(done), 16'd1);
    chk("done_busy", 16'(busy), 16'd0);
    chk("done_op", 16'(op), 16'(exp));
    last_op = exp;
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("done_lo", 16'(done), 16'd0);
    chk("idle_busy", 16'(busy), 16'd0);
    chk("idle_op", 16'(op), 16'(last_op));
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] nx;
    logic [W-1:0] ny;
    bit chain;

    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    last_op = '0;
    repeat (3) @(negedge clk);
    chk("rst_op", 16'(op), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic 9*13 with inputs dropped and a start poke during CALC
    issue(4'd9, 4'd13);
    wait_done(8'd117, 1'b1);
    idle_chk();

    // hold
    for (int i = 0; i < 10; i++) idle_chk();

    issue(4'd15, 4'd15);
    wait_done(8'd225, 1'b0);
    idle_chk();
    issue(4'd0, 4'd7);
    wait_done(8'd0, 1'b0);
    idle_chk();
    issue(4'd1, 4'd1);
    wait_done(8'd1, 1'b0);
    idle_chk();

    // back-to-back
    issue(4'd3, 4'd5);
    wait_done(8'd15, 1'b0);
    issue(4'd6, 4'd7);
    wait_done(8'd42, 1'b0);
    idle_chk();

    // reset mid-operation
    issue(4'd9, 4'd13);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    last_op = '0;
    chk("abort_op", 16'(op), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 8; i++) idle_chk();

    // randomized, with random chaining on the DONE cycle
    x = W'($urandom_range(0, (1 << W) - 1));
    y = W'($urandom_range(0, (1 << W) - 1));
    issue(x, y);
    for (int n = 0; n < 40; n++) begin
      wait_done((2*W)'(int'(x) * int'(y)), bit'($urandom_range(0, 1)));
      nx = W'($urandom_range(0, (1 << W) - 1));
      ny = W'($urandom_range(0, (1 << W) - 1));
      chain = bit'($urandom_range(0, 1));
      if (!chain) idle_chk();
      x = nx;
      y = ny;
      issue(x, y);
    end
    wait_done((2*W)'(int'(x) * int'(y)), 1'b0);
    idle_chk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mul.md
Name: seq_mul

Overview:
Sequential unsigned shift-add multiplier. Captures two WIDTH-bit operands on a one-cycle start pulse and iterates one partial product per clock. It then presents the 2*WIDTH-bit product on op with a one-cycle done strobe. It is a small arithmetic leaf block used wherever a low-area multiply with multi-cycle latency is acceptable.

Parameters:
WIDTH, 4, operand width in bits; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; sampled high on a rising edge starts a multiply of a*b
a  input  WIDTH  multiplicand, unsigned, sampled only on the accepting edge
b  input  WIDTH  multiplier, unsigned, sampled only on the accepting edge
op  output  2*WIDTH  product register; holds last completed result
done  output  1  high for exactly one cycle when op has just been updated
busy  output  1  high while an operation is in progress (CALC state)

Behaviour:
- Reset: when rst_n=0 at a rising edge: state=IDLE, op=0, done=0, busy=0, internal registers cleared. Reset has priority over start and aborts any operation in progress; no done is produced for the aborted operation.
- States: IDLE, CALC, DONE.
- IDLE: if start=1 at edge, latch a into multiplicand register (zero-extended to 2*WIDTH), latch b into multiplier register, clear accumulator, clear iteration counter, go to CALC, busy=1. Otherwise stay in IDLE.
- CALC, one step per edge:
  - If the multiplier LSB is 1, add multiplicand to accumulator (2*WIDTH-bit add, cannot overflow).
  - Shift multiplicand left 1, shift multiplier right 1, increment counter.
  - After the WIDTH-th step, write the final accumulator value (including that step's add) into op, set done=1, busy=0, go to DONE.
- DONE: lasts one cycle; done=1. At the next edge done returns to 0 and the state goes to IDLE. If start=1 on that edge, the new operation is accepted exactly as from IDLE, which allows back-to-back operation.
- start is ignored while in CALC; a, b changes after the accepting edge have no effect on the running operation.
- Latency: start accepted on edge E0; op valid and done=1 after edge E0+WIDTH (WIDTH=4: after the 4th edge following acceptance). Throughput one result per WIDTH+1 cycles.
- op is updated only on completion; it retains the previous result (or 0 after reset) throughout CALC.
- Arithmetic: unsigned only; full-precision product, no truncation; max 4-bit result 15*15=225.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- Basic multiply: reset, then start=1 one cycle with a=4'b1001, b=4'b1101 -> after 4 edges op=8'd117 (0x75), done high exactly one cycle, busy high for the 4 CALC cycles.
- Extremes: a=15, b=15 -> op=225. a=0, b=7 -> op=0 with done pulse. a=1, b=1 -> op=1.
- Input stability: change a/b to 0 and drop start the cycle after acceptance (a=9, b=13) -> op still 117. Assert start=1 with a=2, b=3 during CALC -> ignored; op=117 and no extra done.
- Back-to-back: start(a=3, b=5) accepted; assert start(a=6, b=7) on the DONE cycle -> op=15 with done, then op=42 with done WIDTH+1 cycles later.
- Reset mid-operation: start(a=9, b=13), drive rst_n=0 at 2nd CALC edge -> op=0, done=0, busy=0, state IDLE. No later done pulse until a new start.
- Hold: after a completed 117 result, no start for 10 cycles -> op stays 117, done stays 0.
